// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage and its PC sub-block.
// The bus packer places PC+2 and the instruction word into the IF/ID latch format.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_INC      = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_e;

  localparam logic [15:0] NOP                 = 16'h0000;
  localparam logic [15:0] RESET_PC_DEFAULT    = 16'h0000;
  localparam logic [3:0]  HALT_OPCODE_DEFAULT = 4'hF;

  localparam int PCP2_LSB  = 97;
  localparam int PCP2_MSB  = 112;
  localparam int INSTR_LSB = 0;
  localparam int INSTR_MSB = 15;
  localparam int BUS_W     = 134;

  function automatic logic [BUS_W-1:0] pack_fetch_bus(input logic [15:0] pc_plus2,
                                                      input logic [15:0] instr);
    logic [BUS_W-1:0] bus;
    bus = {BUS_W{1'b0}};
    bus[PCP2_MSB:PCP2_LSB]   = pc_plus2;
    bus[INSTR_MSB:INSTR_LSB] = instr;
    return bus;
  endfunction

endpackage

// File: rtl/fetch_pc.sv
// Program counter register with its +2 incrementer and next-PC selection.
// Redirect targets are forced to halfword alignment.
module fetch_pc
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  pc_sel_e     i_sel,
  input  logic [15:0] i_target,
  output logic [15:0] o_pc,
  output logic [15:0] o_pc_plus2
);

  logic [15:0] r_pc;
  logic [15:0] w_pc_plus2;
  logic [15:0] w_pc_next;
  logic        w_unused_target_lsb;

  assign w_pc_plus2          = r_pc + 16'd2;
  assign w_unused_target_lsb = i_target[0];

  always_comb begin
    w_pc_next = r_pc;
    case (i_sel)
      PC_HOLD:     w_pc_next = r_pc;
      PC_INC:      w_pc_next = w_pc_plus2;
      PC_REDIRECT: w_pc_next = {i_target[15:1], 1'b0};
      default:     w_pc_next = r_pc;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign o_pc       = r_pc;
  assign o_pc_plus2 = w_pc_plus2;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: sequences BOOT/RUN/HALT, squashes on redirect and
// builds the IF/ID bus plus its active-low load control.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter logic [3:0]  HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_stall,
  input  logic             i_branch_taken,
  input  logic [15:0]      i_branch_target,
  input  logic [15:0]      i_imem_data,
  output logic [15:0]      o_imem_addr,
  output logic [BUS_W-1:0] o_fetch_bus,
  output logic             o_buff_enable,
  output logic             o_halted,
  output logic [15:0]      o_fetch_count
);

  fetch_state_e r_state;
  fetch_state_e w_next_state;
  pc_sel_e      w_pc_sel;
  logic [15:0]  w_pc;
  logic [15:0]  w_pc_plus2;
  logic [15:0]  w_instr;
  logic         w_buff_enable;
  logic         w_count_inc;
  logic [15:0]  r_fetch_count;

  fetch_pc #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_sel      (w_pc_sel),
    .i_target   (i_branch_target),
    .o_pc       (w_pc),
    .o_pc_plus2 (w_pc_plus2)
  );

  // Redirect outranks every state; a stalled slot still presents the current word
  always_comb begin
    w_next_state  = r_state;
    w_pc_sel      = PC_HOLD;
    w_instr       = NOP;
    w_buff_enable = 1'b0;
    w_count_inc   = 1'b0;
    if (i_reset) begin
      w_next_state = ST_BOOT;
    end else if (i_branch_taken) begin
      w_pc_sel     = PC_REDIRECT;
      w_next_state = ST_RUN;
    end else begin
      case (r_state)
        ST_BOOT: w_next_state = ST_RUN;
        ST_HALT: w_next_state = ST_HALT;
        ST_RUN: begin
          w_instr = i_imem_data;
          if (i_stall) begin
            w_buff_enable = 1'b1;
          end else if (i_imem_data[15:12] == HALT_OPCODE) begin
            w_count_inc  = 1'b1;
            w_next_state = ST_HALT;
          end else begin
            w_count_inc = 1'b1;
            w_pc_sel    = PC_INC;
          end
        end
        default: w_next_state = ST_BOOT;
      endcase
    end
  end

  always_comb begin
    if (i_reset) begin
      o_fetch_bus = {BUS_W{1'b0}};
      o_halted    = 1'b0;
    end else begin
      o_fetch_bus = pack_fetch_bus(w_pc_plus2, w_instr);
      o_halted    = (r_state == ST_HALT);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Saturating count of real instructions handed to the IF/ID buffer
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fetch_count <= 16'h0000;
    end else if (w_count_inc && (r_fetch_count != 16'hFFFF)) begin
      r_fetch_count <= r_fetch_count + 16'd1;
    end else begin
      r_fetch_count <= r_fetch_count;
    end
  end

  assign o_imem_addr   = w_pc;
  assign o_buff_enable = w_buff_enable;
  assign o_fetch_count = r_fetch_count;

endmodule
